stream_packet_arbiter: RTL and testbench
========================================

Name: stream_packet_arbiter

Overview:
- N-to-1 stream arbiter with packet awareness. Grant is locked from the first accepted beat of a packet until its last beat is accepted, so packets from different requesters never interleave.
- Supports round-robin or fixed-priority selection.
- Carries keep/user/last sideband with each beat and tags every output beat with its source index.
- Fixed 2-entry skid output stage: full throughput, registered outputs. Sits in front of MAC TX and shared egress paths where frames from several sources merge.

Parameters:
- NUM_REQS, 4, number of input streams (>=1)
- DATAW, 64, data width per beat
- KEEPW, 8, keep width (DATAW/8)
- USERW, 1, user sideband width
- ARB_TYPE, "R", "R" = round-robin, "P" = fixed priority (index 0 highest)
- LAST_ENABLE, 1, 1 = lock grant per packet; 0 = re-arbitrate every beat (s_last still forwarded)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset)
- s_valid  in  NUM_REQS  per-input valid
- s_ready  out  NUM_REQS  per-input ready
- s_data  in  NUM_REQS*DATAW  input i at [(i+1)*DATAW-1:i*DATAW]
- s_keep  in  NUM_REQS*KEEPW  per-input keep
- s_last  in  NUM_REQS  per-input end of packet
- s_user  in  NUM_REQS*USERW  per-input user
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- m_data  out  DATAW  output data
- m_keep  out  KEEPW  output keep
- m_last  out  1  output last
- m_user  out  USERW  output user
- m_index  out  max(1,clog2(NUM_REQS))  source index of the current output beat
- busy  out  1  1 while in LOCKED state

Behaviour:
- Transfer occurs on a port when valid & ready are both high at a rising clk edge.
- Reset (reset==0 at clk edge):
  - state=IDLE, rr_ptr=0, both skid entries empty.
  - m_valid=0, busy=0, s_ready=0 during reset.
  - m_data/keep/last/user/index = 0.
  - Reset mid-packet drops the partial packet. No recovery beat is emitted.
- Output stage:
  - main register plus one skid register.
  - stage_ready = ~skid_valid (registered). Not combinationally dependent on m_ready.
  - Latency from input acceptance to m_valid is 1 cycle.
  - Sustained 1 beat/cycle while m_ready=1.
  - With m_ready=0, the stage accepts at most 2 beats, then stage_ready drops.
  - Skid drains into main first; order is preserved.
- IDLE:
  - Winner selected combinationally among s_valid.
  - "P": lowest index wins.
  - "R": first valid index at or after rr_ptr, wrapping around.
  - s_ready[winner] = stage_ready; all other s_ready = 0.
  - Winner's beat accepted with s_last=0 and LAST_ENABLE=1 -> LOCKED, gnt_reg = winner.
  - Winner's beat accepted with s_last=1 (single-beat packet) -> remain IDLE, rr_ptr = winner+1 mod NUM_REQS.
  - LAST_ENABLE=0: always remain IDLE; rr_ptr advances on every accepted beat.
  - No valid input: nothing changes.
- LOCKED:
  - Only gnt_reg is served. s_ready[gnt_reg] = stage_ready; all others 0.
  - Other requesters' valid is ignored, even if higher priority.
  - Accepted beat with s_last=1 -> IDLE, rr_ptr = gnt_reg+1 mod NUM_REQS.
  - A new packet may be accepted in the cycle immediately after (no bubble).
  - If gnt_reg deasserts s_valid mid-packet: hold LOCKED and wait, no timeout.
- grant_index semantics: m_index is registered with the beat. Internal gnt_reg/winner is not exported separately.
- Sideband: keep/user/last are passed unchanged with data. No keep-based checks.
- NUM_REQS=1:
  - No arbitration; s_ready[0] = stage_ready; m_index=0.
  - busy still tracks packet state when LAST_ENABLE=1.
- Inputs must hold data stable while valid & ~ready. The block does not check this.

Test Plan:
- Single input 2 valid, 3-beat packet (data 0xA0,0xA1,0xA2, last on 3rd), m_ready=1 -> m_data appears 0xA0..0xA2 on cycles t+1..t+3; m_last on 0xA2; m_index=2; busy=1 for 2 cycles.
- "R", inputs 0 and 1 each continuously send 2-beat packets -> output packets alternate 0,1,0,1 and never interleave within a packet; 100% throughput.
- "P", input 1 mid-packet (LOCKED) when input 0 asserts valid -> input 1's packet completes first; input 0's packet starts the very next cycle.
- m_ready held 0 for 5 cycles while input 3 streams -> exactly 2 beats accepted; s_ready[3]=0 afterwards; on release, beats emerge in order with no loss or duplication.
- LAST_ENABLE=0, "R", all 4 inputs valid with s_last=0 -> m_index cycles 0,1,2,3,0; busy stays 0.
- reset driven to 0 mid-packet, then released with input 2 valid -> m_valid=0 and busy=0 during reset; rr_ptr=0, so "R" grants the lowest valid index (2) after release.

Source files
------------

// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter: packet-locked N-to-1 stream arbiter; s_* streams merge onto registered m_* tagged with m_index, busy while a packet holds the grant
module stream_packet_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 64,
  parameter int KEEPW = 8,
  parameter int USERW = 1,
  parameter ARB_TYPE = "R",
  parameter bit LAST_ENABLE = 1'b1,
  localparam int IW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       s_valid,
  output logic [NUM_REQS-1:0]       s_ready,
  input  logic [NUM_REQS*DATAW-1:0] s_data,
  input  logic [NUM_REQS*KEEPW-1:0] s_keep,
  input  logic [NUM_REQS-1:0]       s_last,
  input  logic [NUM_REQS*USERW-1:0] s_user,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATAW-1:0]          m_data,
  output logic [KEEPW-1:0]          m_keep,
  output logic                      m_last,
  output logic [USERW-1:0]          m_user,
  output logic [IW-1:0]             m_index,
  output logic                      busy
);
  localparam bit PRIO = ARB_TYPE == "P";
  localparam int BW = IW + 1 + USERW + KEEPW + DATAW;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] gnt_reg, gnt_nxt, rr_ptr, rr_nxt, win_idx, lo_idx, up_idx, sel_idx;
  logic up_hit, win_valid, stage_ready, in_fire, in_last, skid_valid;
  logic [BW-1:0] in_beat, skid_beat, m_beat;
  always_comb begin
    lo_idx = '0;
    up_idx = '0;
    up_hit = 1'b0;
    for (int c = NUM_REQS - 1; c >= 0; c--) begin
      if (s_valid[c]) begin
        lo_idx = IW'(c);
        if (IW'(c) >= rr_ptr) begin
          up_idx = IW'(c);
          up_hit = 1'b1;
        end
      end
    end
    win_valid = |s_valid;
    win_idx = (up_hit && !PRIO) ? up_idx : lo_idx;
    sel_idx = state == LOCKED ? gnt_reg : win_idx;
  end
  always_comb begin
    in_beat = '0;
    for (int c = 0; c < NUM_REQS; c++)
      if (IW'(c) == sel_idx)
        in_beat = {sel_idx, s_last[c], s_user[c*USERW +: USERW], s_keep[c*KEEPW +: KEEPW], s_data[c*DATAW +: DATAW]};
  end
  assign in_last = in_beat[BW-IW-1];
  assign in_fire = |(s_valid & s_ready);
  assign stage_ready = ~skid_valid;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt_reg <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      gnt_reg <= gnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    gnt_nxt = gnt_reg;
    rr_nxt = rr_ptr;
    if (in_fire) begin
      state_nxt = (LAST_ENABLE && !in_last) ? LOCKED : IDLE;
      gnt_nxt = sel_idx;
      rr_nxt = (LAST_ENABLE && !in_last) ? rr_ptr : (sel_idx == IW'(NUM_REQS - 1) ? '0 : sel_idx + IW'(1));
    end
  end
  always_comb begin
    s_ready = '0;
    for (int c = 0; c < NUM_REQS; c++)
      s_ready[c] = reset && stage_ready && (state == LOCKED || win_valid) && IW'(c) == sel_idx;
    busy = state == LOCKED;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
      skid_valid <= 1'b0;
      m_beat <= '0;
      skid_beat <= '0;
    end else if (!m_valid || m_ready) begin
      m_valid <= skid_valid || in_fire;
      m_beat <= skid_valid ? skid_beat : in_fire ? in_beat : m_beat;
      skid_valid <= 1'b0;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_beat <= in_beat;
    end
  end
  assign {m_index, m_last, m_user, m_keep, m_data} = m_beat;
endmodule

// File: tb/tb_stream_packet_arbiter.sv
// tb_stream_packet_arbiter: drives round-robin, fixed-priority and per-beat arbiter instances and checks them against tables, hand sequences and a queue model
module tb_stream_packet_arbiter;
  localparam int N = 4, DW = 64, KW = 8, UW = 1, IW = 2;
  typedef struct {int idx; bit last; logic [63:0] data; int cyc;} beat_t;
  typedef struct {int prev; logic [3:0] v; logic [3:0] er; logic [3:0] ep;} vec_t;
  logic clk = 0, reset = 0;
  logic [2:0][N-1:0] s_valid, s_ready, s_last;
  logic [2:0][N*DW-1:0] s_data;
  logic [2:0][N*KW-1:0] s_keep;
  logic [2:0][N*UW-1:0] s_user;
  logic [2:0] m_valid, m_ready, m_last, busy;
  logic [2:0][DW-1:0] m_data;
  logic [2:0][KW-1:0] m_keep;
  logic [2:0][UW-1:0] m_user;
  logic [2:0][IW-1:0] m_index;
  int checks = 0, failures = 0, cyc = 0;
  int busy_cnt[3], in_cnt[3];
  beat_t oq[3][$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    stream_packet_arbiter #(.NUM_REQS(N), .DATAW(DW), .KEEPW(KW), .USERW(UW),
      .ARB_TYPE(k == 1 ? "P" : "R"), .LAST_ENABLE(k == 2 ? 1'b0 : 1'b1)) u_dut (
      .clk(clk), .reset(reset), .s_valid(s_valid[k]), .s_ready(s_ready[k]), .s_data(s_data[k]),
      .s_keep(s_keep[k]), .s_last(s_last[k]), .s_user(s_user[k]), .m_valid(m_valid[k]),
      .m_ready(m_ready[k]), .m_data(m_data[k]), .m_keep(m_keep[k]), .m_last(m_last[k]),
      .m_user(m_user[k]), .m_index(m_index[k]), .busy(busy[k]));
  end
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (reset)
      for (int k = 0; k < 3; k++) begin
        if (m_valid[k] && m_ready[k]) oq[k].push_back('{int'(m_index[k]), m_last[k], m_data[k], cyc});
        if (busy[k]) busy_cnt[k]++;
        in_cnt[k] += $countones(s_valid[k] & s_ready[k]);
      end
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(int k, int i, bit v, logic [63:0] d, bit l);
    s_valid[k][i] = v;
    s_last[k][i] = l;
    s_data[k][i*DW +: DW] = d;
    s_keep[k][i*KW +: KW] = d[7:0];
    s_user[k][i] = d[0];
  endtask
  task automatic clear_mon();
    for (int k = 0; k < 3; k++) begin
      oq[k].delete();
      busy_cnt[k] = 0;
      in_cnt[k] = 0;
    end
  endtask
  task automatic hold_reset();
    reset = 0;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    s_keep = '0;
    s_user = '0;
    m_ready = '1;
    repeat (2) tick();
  endtask
  task automatic do_reset();
    hold_reset();
    reset = 1;
    clear_mon();
  endtask
  task automatic beat(int k, int i, logic [63:0] d, bit l);
    int t = 0;
    put(k, i, 1, d, l);
    @(negedge clk);
    while (!s_ready[k][i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout dut=%0d in=%0d got no ready expected ready", k, i);
    end
    tick();
  endtask
  task automatic send(int k, int i, logic [63:0] base, int len);
    for (int b = 0; b < len; b++) beat(k, i, base + 64'(b), b == len - 1);
    put(k, i, 0, 0, 0);
  endtask
  task automatic run_random();
    int owner = -1, rr = 0, grant, seq = 0, j;
    bit sr;
    bit pend[N];
    bit gl[N];
    logic [63:0] gd[N];
    logic [3:0] exp_rdy;
    beat_t mq[$];
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1;
          gd[i] = {32'(i), 32'(seq)};
          gl[i] = $urandom_range(0, 2) == 0;
          seq++;
        end
        put(0, i, pend[i], gd[i], gl[i]);
      end
      m_ready[0] = $urandom_range(0, 3) != 0;
      @(negedge clk);
      grant = owner;
      for (int c = 0; c < N; c++) begin
        j = (rr + c) % N;
        if (grant < 0 && pend[j]) grant = j;
      end
      sr = mq.size() < 2;
      exp_rdy = (sr && grant >= 0) ? 4'(1 << grant) : 4'b0;
      chk("rnd_s_ready", s_ready[0], exp_rdy);
      chk("rnd_m_valid", m_valid[0], mq.size() > 0);
      chk("rnd_busy", busy[0], owner >= 0);
      if (mq.size() > 0) begin
        chk("rnd_m_data", m_data[0], mq[0].data);
        chk("rnd_m_index", m_index[0], mq[0].idx);
        chk("rnd_m_last", m_last[0], mq[0].last);
        chk("rnd_m_keep", m_keep[0], mq[0].data[7:0]);
        chk("rnd_m_user", m_user[0], mq[0].data[0]);
        if (m_ready[0]) void'(mq.pop_front());
      end
      if (sr && grant >= 0 && pend[grant]) begin
        mq.push_back('{grant, gl[grant], gd[grant], 0});
        pend[grant] = 0;
        owner = gl[grant] ? -1 : grant;
        rr = gl[grant] ? (grant + 1) % N : rr;
      end
      tick();
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{-1, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{-1, 4'b1010, 4'b0010, 4'b0010};
    tbl[2] = '{0, 4'b0011, 4'b0010, 4'b0001};
    tbl[3] = '{1, 4'b1001, 4'b1000, 4'b0001};
    tbl[4] = '{3, 4'b1100, 4'b0100, 4'b0100};
    tbl[5] = '{2, 4'b0111, 4'b0001, 4'b0001};
    tbl[6] = '{-1, 4'b1111, 4'b0001, 4'b0001};
    tbl[7] = '{2, 4'b1111, 4'b1000, 4'b0001};
    for (int e = 0; e < 8; e++) begin
      hold_reset();
      s_valid[0] = tbl[e].v;
      s_valid[1] = tbl[e].v;
      @(negedge clk);
      chk("tbl_rst_s_ready", s_ready[0], 0);
      chk("tbl_rst_m_valid", m_valid, 0);
      chk("tbl_rst_busy", busy, 0);
      chk("tbl_rst_m_data", m_data[0], 0);
      chk("tbl_rst_m_index", m_index[0], 0);
      s_valid = '0;
      tick();
      reset = 1;
      if (tbl[e].prev >= 0) send(0, tbl[e].prev, 64'h55, 1);
      s_valid[0] = tbl[e].v;
      s_valid[1] = tbl[e].v;
      @(negedge clk);
      chk($sformatf("tbl%0d_rr_ready", e), s_ready[0], tbl[e].er);
      chk($sformatf("tbl%0d_prio_ready", e), s_ready[1], tbl[e].ep);
      s_valid = '0;
      tick();
    end
    do_reset();
    send(0, 2, 64'hA0, 3);
    repeat (3) tick();
    chk("pkt_count", oq[0].size(), 3);
    for (int j = 0; j < 3 && j < oq[0].size(); j++) begin
      chk("pkt_data", oq[0][j].data, 64'hA0 + 64'(j));
      chk("pkt_index", oq[0][j].idx, 2);
      chk("pkt_last", oq[0][j].last, j == 2);
      if (j > 0) chk("pkt_gap", oq[0][j].cyc - oq[0][j-1].cyc, 1);
    end
    chk("pkt_busy_cycles", busy_cnt[0], 2);
    do_reset();
    fork
      for (int p = 0; p < 4; p++) send(0, 0, 64'h100 + 64'(16 * p), 2);
      for (int p = 0; p < 4; p++) send(0, 1, 64'h1100 + 64'(16 * p), 2);
    join
    repeat (3) tick();
    chk("rr_count", oq[0].size(), 16);
    for (int j = 0; j < 16 && j < oq[0].size(); j++) begin
      chk("rr_index", oq[0][j].idx, (j / 2) % 2);
      chk("rr_data", oq[0][j].data, ((j / 2) % 2 ? 64'h1100 : 64'h100) + 64'(16 * (j / 4) + j % 2));
      if (j > 0) chk("rr_gap", oq[0][j].cyc - oq[0][j-1].cyc, 1);
    end
    do_reset();
    fork
      send(1, 1, 64'hB0, 3);
      begin
        tick();
        send(1, 0, 64'hC0, 2);
      end
    join
    repeat (3) tick();
    chk("prio_count", oq[1].size(), 5);
    for (int j = 0; j < 5 && j < oq[1].size(); j++) begin
      chk("prio_index", oq[1][j].idx, j < 3 ? 1 : 0);
      chk("prio_data", oq[1][j].data, j < 3 ? 64'hB0 + 64'(j) : 64'hC0 + 64'(j - 3));
      if (j > 0) chk("prio_gap", oq[1][j].cyc - oq[1][j-1].cyc, 1);
    end
    do_reset();
    m_ready[0] = 0;
    fork
      send(0, 3, 64'hD0, 6);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_accepted", in_cnt[0], 2);
        chk("stall_s_ready", s_ready[0][3], 0);
        chk("stall_m_valid", m_valid[0], 1);
        tick();
        m_ready[0] = 1;
      end
    join
    repeat (4) tick();
    chk("stall_count", oq[0].size(), 6);
    for (int j = 0; j < 6 && j < oq[0].size(); j++) begin
      chk("stall_data", oq[0][j].data, 64'hD0 + 64'(j));
      chk("stall_index", oq[0][j].idx, 3);
    end
    do_reset();
    for (int i = 0; i < N; i++) put(2, i, 1, 64'hE0 + 64'(i), 0);
    repeat (6) tick();
    s_valid[2] = '0;
    repeat (3) tick();
    chk("beat_rr_count", oq[2].size(), 6);
    for (int j = 0; j < 5 && j < oq[2].size(); j++) begin
      chk("beat_rr_index", oq[2][j].idx, j % 4);
      chk("beat_rr_data", oq[2][j].data, 64'hE0 + 64'(j % 4));
    end
    chk("beat_rr_busy", busy_cnt[2], 0);
    do_reset();
    send(0, 2, 64'hF0, 1);
    put(0, 3, 1, 64'hF1, 0);
    tick();
    chk("midrst_locked", busy[0], 1);
    reset = 0;
    put(0, 3, 1, 64'hF2, 0);
    put(0, 2, 1, 64'hF3, 1);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", m_valid[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_s_ready", s_ready[0], 0);
    chk("midrst_m_index", m_index[0], 0);
    tick();
    reset = 1;
    clear_mon();
    @(negedge clk);
    chk("midrst_grant", s_ready[0], 4'b0100);
    tick();
    s_valid[0] = '0;
    repeat (2) tick();
    chk("midrst_first_idx", oq[0].size() > 0 ? oq[0][0].idx : -1, 2);
    chk("midrst_first_data", oq[0].size() > 0 ? oq[0][0].data : 64'h0, 64'hF3);
    run_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
